gate_stream_unit: RTL and testbench
===================================

Name: gate_stream_unit

Overview:
- Parametrised, registered successor to the single-bit switch-level XOR gate.
- Applies a selectable bitwise logic function (AND/OR/XOR/NAND/NOR/XNOR/pass/invert) to two WIDTH-bit operands.
- Operands arrive over a valid/ready stream. Result is registered with a parity bit.
- Keeps a running XOR accumulation across frames of FRAME_LEN beats, for use as a datapath/parity building block in the gate library.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- FRAME_LEN, 4, accepted beats per accumulation frame (>=1).
- CNT_W, derived = max(1, $clog2(FRAME_LEN)), beat counter width (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  3  function select, sampled with the beat.
- frame_clr  in  1  synchronous restart of the current frame.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  WIDTH  registered f(a,b).
- y_par  out  1  reduction XOR of y.
- acc  out  WIDTH  running XOR of y over the current frame, including this beat.
- frame_done  out  1  this result is the last beat of a frame.
- beat_cnt  out  CNT_W  index of the next beat within the frame.

Behaviour:
- Reset (async assert, sync release): y, y_par, acc, beat_cnt, out_valid and frame_done are all 0. in_ready is 1 after reset.
- Mode encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 A, 111 ~A.
  - All functions are bitwise over WIDTH; b is ignored for 110/111.
- in_ready = !out_valid || out_ready (combinational). Single output register, no skid buffer.
- Accept = in_valid && in_ready.
- Latency: 1 cycle, accept to out_valid.
- Throughput: 1 beat/cycle while out_ready = 1.
- On accept, at the next edge:
  - y <= f; y_par <= ^f; out_valid <= 1.
  - If beat_cnt == 0 or frame_clr: acc <= f. Otherwise acc <= acc ^ f.
  - frame_done <= 1 if the effective index == FRAME_LEN-1, else 0. The effective index is 0 when frame_clr, else beat_cnt.
  - beat_cnt <= effective index + 1, wrapping to 0 after FRAME_LEN-1.
- Output consumed with no new accept (out_valid && out_ready && !accept):
  - out_valid <= 0, frame_done <= 0.
  - y, y_par and acc hold their last values.
- Stall (out_valid && !out_ready): y, y_par, acc, frame_done, beat_cnt all held; no accept.
- frame_clr without accept: beat_cnt <= 0. acc is unchanged until the next accept, which restarts acc.
- frame_clr with accept: the accepted beat is beat 0 of a new frame.
- FRAME_LEN = 1: every beat asserts frame_done, acc == y, beat_cnt stays 0.
- Simultaneous consume and accept: out_valid stays 1 and new data replaces old in the same edge (back-to-back).
- Reset asserted mid-frame: immediate clear of all state; the next frame starts at beat 0 and any partial acc is discarded.
- mode, a and b are only sampled on accept. Changes while not accepting have no effect.

Test Plan:
1. Reset: rst_n=0 asynchronously, with no clock edge -> y=00, acc=00, out_valid=0, frame_done=0, beat_cnt=0. After release, in_ready=1.
2. Mode sweep, WIDTH=8, a=F0, b=CC, out_ready=1, one beat per mode 000..111:
   - y = C0, FC, 3C, 3F, 03, C3, F0, 0F.
   - y_par = 0 for all eight results.
   - Each result appears 1 cycle after accept.
3. Frame accumulation, FRAME_LEN=4, mode XOR, b=00, a=01,02,04,08 on back-to-back cycles:
   - acc = 01, 03, 07, 0F.
   - frame_done=1 only with y=08; beat_cnt returns to 0.
   - A 5th beat a=10 gives acc=10.
4. Backpressure: a=A5, b=0F, XOR accepted, then out_ready=0 for 3 cycles with in_valid=1 and a=FF:
   - in_ready=0 and y held at AA, y_par=0.
   - After out_ready=1, AA is consumed and the next result is F0.
5. frame_clr: 2 XOR beats (a=01, a=02 -> acc=03), then frame_clr=1 with a=80 -> acc=80, beat_cnt=1, frame_done=0. frame_clr alone -> beat_cnt=0.
6. Reset mid-frame: after 2 of 4 beats, pulse rst_n low -> outputs zero immediately. The next 4 beats (01,02,04,08) produce frame_done on the 4th with acc=0F.

Source files
------------

// File: rtl/gate_stream_unit.sv
// gate_stream_unit
//
// Registered bitwise logic unit with a valid/ready operand stream. Each
// accepted beat applies the selected function to a and b. The unit registers
// the result together with its parity bit. It also keeps a running XOR of
// results across frames of FRAME_LEN beats. It serves as a datapath and
// parity building block in the gate library.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 1)
//   FRAME_LEN  accepted beats per accumulation frame (>= 1)
//   CNT_W      beat counter width, derived from FRAME_LEN
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operand beat valid
//   in_ready    unit can accept a beat this cycle
//   a, b        operands
//   mode        function select, sampled on accept:
//               000 AND, 001 OR, 010 XOR, 011 NAND,
//               100 NOR, 101 XNOR, 110 a, 111 ~a
//   frame_clr   synchronous restart of the current frame
//   out_valid   result valid
//   out_ready   downstream accepts the result
//   y           registered f(a, b)
//   y_par       reduction XOR of y
//   acc         running XOR of y over the current frame, this beat included
//   frame_done  this result is the last beat of a frame
//   beat_cnt    index of the next beat within the frame

module gate_stream_unit #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    localparam int CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             frame_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_par,
    output logic [WIDTH-1:0] acc,
    output logic             frame_done,
    output logic [CNT_W-1:0] beat_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] f;
    logic [CNT_W-1:0] eff_idx;
    logic             eff_last;
    logic [CNT_W-1:0] next_idx;

    // There is a single output register and no skid buffer. A new beat can
    // enter only when that register is empty or is drained at the same edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_comb begin
        f = '0;
        case (mode)
            3'b000:  f = a & b;
            3'b001:  f = a | b;
            3'b010:  f = a ^ b;
            3'b011:  f = ~(a & b);
            3'b100:  f = ~(a | b);
            3'b101:  f = ~(a ^ b);
            3'b110:  f = a;
            3'b111:  f = ~a;
            default: f = '0;
        endcase
    end

    // A frame_clr that arrives with a beat makes that beat index 0. The beat
    // is then both the frame start and the seed of the accumulator.
    assign eff_idx  = frame_clr ? '0 : beat_cnt;
    assign eff_last = (eff_idx == LAST_IDX);
    assign next_idx = eff_last ? '0 : (eff_idx + CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y          <= '0;
            y_par      <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            beat_cnt   <= '0;
        end else if (accept) begin
            y          <= f;
            y_par      <= ^f;
            out_valid  <= 1'b1;
            acc        <= (eff_idx == '0) ? f : (acc ^ f);
            frame_done <= eff_last;
            beat_cnt   <= next_idx;
        end else begin
            if (consume) begin
                out_valid  <= 1'b0;
                frame_done <= 1'b0;
            end
            // The accumulator keeps its value here. It restarts on the next
            // accepted beat, because that beat will see beat_cnt == 0.
            if (frame_clr) begin
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gate_stream_unit.sv
module tb_gate_stream_unit;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       mode;
    logic             frame_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_par;
    logic [WIDTH-1:0] acc;
    logic             frame_done;
    logic [1:0]       beat_cnt;

    gate_stream_unit #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .mode       (mode),
        .frame_clr  (frame_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .y_par      (y_par),
        .acc        (acc),
        .frame_done (frame_done),
        .beat_cnt   (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             par;
        logic [WIDTH-1:0] acc;
        logic             done;
        int               cnt;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;
    logic [WIDTH-1:0] m_acc = '0;

    function automatic logic [WIDTH-1:0] ref_fn(input logic [2:0] m, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        case (m)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    // Scoreboard: on each edge, first retire a transferred result, then book
    // the result of any beat accepted at this edge.
    always @(posedge clk) begin
        exp_t e;
        exp_t n;
        int   idx;
        logic [WIDTH-1:0] fv;
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            m_acc = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("sb_y", 32'(y), 32'(e.y));
                    chk("sb_par", 32'(y_par), 32'(e.par));
                    chk("sb_acc", 32'(acc), 32'(e.acc));
                    chk("sb_done", 32'(frame_done), 32'(e.done));
                    chk("sb_cnt", 32'(beat_cnt), 32'(e.cnt));
                end
            end
            if (in_valid && (!out_valid || out_ready)) begin
                idx    = frame_clr ? 0 : m_cnt;
                fv     = ref_fn(mode, a, b);
                m_acc  = (idx == 0) ? fv : (m_acc ^ fv);
                m_cnt  = (idx + 1) % FRAME_LEN;
                n.y    = fv;
                n.par  = ^fv;
                n.acc  = m_acc;
                n.done = (idx == FRAME_LEN - 1);
                n.cnt  = m_cnt;
                q.push_back(n);
            end else if (frame_clr) begin
                m_cnt = 0;
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic [2:0] m,
                         input logic v, input logic clr, input logic rdy);
        a         = av;
        b         = bv;
        mode      = m;
        in_valid  = v;
        frame_clr = clr;
        out_ready = rdy;
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] mode_tbl [8];
    logic [WIDTH-1:0] acc_tbl  [4];
    logic [WIDTH-1:0] av;

    initial begin
        mode_tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
        acc_tbl  = '{8'h01, 8'h03, 8'h07, 8'h0F};
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = '0;
        frame_clr = 1'b0;
        out_ready = 1'b1;

        // 1: asynchronous reset before the first clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_acc", 32'(acc), 32'h0);
        chk("rst_ovalid", 32'(out_valid), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_cnt", 32'(beat_cnt), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_iready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // 2: mode sweep, one result per cycle
        for (int m = 0; m < 8; m++) begin
            drive(8'hF0, 8'hCC, 3'(m), 1'b1, 1'b0, 1'b1);
            chk("mode_valid", 32'(out_valid), 32'h1);
            chk("mode_y", 32'(y), 32'(mode_tbl[m]));
            chk("mode_par", 32'(y_par), 32'h0);
        end
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_idle_cnt", 32'(beat_cnt), 32'h0);

        // 3: frame accumulation
        for (int i = 0; i < 4; i++) begin
            av = 8'h01 << i;
            drive(av, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
            chk("frm_acc", 32'(acc), 32'(acc_tbl[i]));
            chk("frm_done", 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("frm_cnt_wrap", 32'(beat_cnt), 32'h0);
        drive(8'h10, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("frm5_acc", 32'(acc), 32'h10);
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

        // 4: backpressure
        drive(8'hA5, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("bp_y0", 32'(y), 32'hAA);
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b0);
            chk("bp_iready", 32'(in_ready), 32'h0);
            chk("bp_y_hold", 32'(y), 32'hAA);
            chk("bp_par", 32'(y_par), 32'h0);
        end
        drive(8'hFF, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("bp_next_y", 32'(y), 32'hF0);
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);

        // 5: frame_clr
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        drive(8'h01, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        drive(8'h02, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("clr_acc2", 32'(acc), 32'h03);
        drive(8'h80, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1);
        chk("clr_acc", 32'(acc), 32'h80);
        chk("clr_cnt", 32'(beat_cnt), 32'h1);
        chk("clr_done", 32'(frame_done), 32'h0);
        drive(8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_alone_cnt", 32'(beat_cnt), 32'h0);

        // 6: reset in the middle of a frame
        drive(8'h01, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        drive(8'h02, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst_y", 32'(y), 32'h0);
        chk("mrst_acc", 32'(acc), 32'h0);
        chk("mrst_ovalid", 32'(out_valid), 32'h0);
        chk("mrst_cnt", 32'(beat_cnt), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            av = 8'h01 << i;
            drive(av, 8'h00, 3'd2, 1'b1, 1'b0, 1'b1);
            chk("mrst_done", 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("mrst_acc_f", 32'(acc), 32'h0F);

        // drain the scoreboard within a bounded number of cycles
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
